// File: rtl/montre_sysid_pkg.sv
// Shared constants and helpers for the montre system-ID / uptime register bank.
// Word map, CTRL/CAPS bit positions and default identity values live here.
package montre_sysid_pkg;

    typedef enum logic [2:0] {
        ADDR_ID        = 3'd0,
        ADDR_TIMESTAMP = 3'd1,
        ADDR_UPTIME_LO = 3'd2,
        ADDR_UPTIME_HI = 3'd3,
        ADDR_SCRATCH   = 3'd4,
        ADDR_CTRL      = 3'd5,
        ADDR_CAPS      = 3'd6,
        ADDR_RSVD      = 3'd7
    } addr_e;

    localparam int CTRL_CLEAR_BIT    = 0;
    localparam int CTRL_HOLD_BIT     = 1;

    localparam int CAPS_PRESCALE_LSB = 16;
    localparam int CAPS_UPTIME_BIT   = 0;

    localparam int PRESCALE_W        = 16;

    localparam logic [31:0] DEFAULT_SYSTEM_ID = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TIMESTAMP = 32'd1698362541;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    function automatic logic [31:0] caps_word(input logic [PRESCALE_W-1:0] prescale,
                                              input logic                  uptime_present);
        logic [31:0] word;
        word = '0;
        word[CAPS_PRESCALE_LSB +: PRESCALE_W] = prescale;
        word[CAPS_UPTIME_BIT]                 = uptime_present;
        return word;
    endfunction

endpackage

// File: rtl/montre_uptime_counter.sv
// Prescaled 64-bit uptime counter with CLEAR/HOLD control and a HI-word shadow
// that is latched whenever the LO word is read, so LO-then-HI reads are coherent.
module montre_uptime_counter
    import montre_sysid_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_hold,
    input  logic        i_snap,
    output logic [31:0] o_uptime_lo,
    output logic [31:0] o_snap_hi
);

    localparam logic [PRESCALE_W-1:0] TERMINAL = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] r_prescale_cnt;
    logic [63:0]           r_uptime;
    logic [31:0]           r_snap_hi;
    logic                  w_tick;

    assign w_tick = (r_prescale_cnt == TERMINAL);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prescale_cnt <= '0;
            r_uptime       <= '0;
            r_snap_hi      <= '0;
        end else begin
            // CLEAR outranks both HOLD and a coincident tick.
            if (i_clear) begin
                r_prescale_cnt <= '0;
                r_uptime       <= '0;
            end else if (!i_hold) begin
                if (w_tick) begin
                    r_prescale_cnt <= '0;
                    r_uptime       <= r_uptime + 64'd1;
                end else begin
                    r_prescale_cnt <= r_prescale_cnt + 1'b1;
                end
            end
            if (i_snap) r_snap_hi <= r_uptime[63:32];
        end
    end

    assign o_uptime_lo = r_uptime[31:0];
    assign o_snap_hi   = r_snap_hi;

endmodule

// File: rtl/montre_sysid_regs.sv
// Avalon-MM system-ID / uptime register bank with one-cycle registered reads.
// Define MONTRE_SYSID_UPTIME_EN to build the prescaled uptime counter and CTRL.
module montre_sysid_regs
    import montre_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID = DEFAULT_SYSTEM_ID,
    parameter logic [31:0] TIMESTAMP = DEFAULT_TIMESTAMP,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_FIELD = PRESCALE_W'(PRESCALE);

    addr_e       w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_uptime_lo;
    logic [31:0] w_snap_hi;
    logic        w_hold;
    logic        w_uptime_present;

    logic [31:0] r_scratch;
    logic [31:0] r_readdata;
    logic        r_readdatavalid;

    assign w_addr = addr_e'(address);

`ifdef MONTRE_SYSID_UPTIME_EN
    logic r_hold;
    logic w_ctrl_wr;
    logic w_clear;

    assign w_ctrl_wr        = write && (w_addr == ADDR_CTRL) && byteenable[0];
    assign w_clear          = w_ctrl_wr && writedata[CTRL_CLEAR_BIT];
    assign w_hold           = r_hold;
    assign w_uptime_present = 1'b1;

    always_ff @(posedge clock) begin
        if (reset)          r_hold <= 1'b0;
        else if (w_ctrl_wr) r_hold <= writedata[CTRL_HOLD_BIT];
    end

    montre_uptime_counter #(
        .PRESCALE (PRESCALE)
    ) u_uptime (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_hold      (r_hold),
        .i_snap      (read && (w_addr == ADDR_UPTIME_LO)),
        .o_uptime_lo (w_uptime_lo),
        .o_snap_hi   (w_snap_hi)
    );
`else
    assign w_uptime_lo      = '0;
    assign w_snap_hi        = '0;
    assign w_hold           = 1'b0;
    assign w_uptime_present = 1'b0;
`endif

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            ADDR_ID:        w_rdata = SYSTEM_ID;
            ADDR_TIMESTAMP: w_rdata = TIMESTAMP;
            ADDR_UPTIME_LO: w_rdata = w_uptime_lo;
            ADDR_UPTIME_HI: w_rdata = w_snap_hi;
            ADDR_SCRATCH:   w_rdata = r_scratch;
            ADDR_CTRL:      w_rdata[CTRL_HOLD_BIT] = w_hold;
            ADDR_CAPS:      w_rdata = caps_word(PRESCALE_FIELD, w_uptime_present);
            ADDR_RSVD:      w_rdata = '0;
            default:        w_rdata = '0;
        endcase
    end

    // Read data is captured from pre-edge state, so a same-cycle write is not visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scratch       <= '0;
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= read;
            r_readdata      <= read ? w_rdata : '0;
            if (write && (w_addr == ADDR_SCRATCH))
                r_scratch <= merge_bytes(r_scratch, writedata, byteenable);
        end
    end

    // A response still in flight when reset arrives is suppressed rather than delivered.
    assign readdatavalid = r_readdatavalid & ~reset;
    assign readdata      = reset ? '0 : r_readdata;

endmodule

// File: tb/tb_montre_sysid_regs.sv
// Self-checking bench for montre_sysid_regs: directed scenarios plus random traffic
// compared each cycle against a behavioural model of the register map.
module tb_montre_sysid_regs;

    localparam int unsigned P      = 4;
    localparam logic [31:0] TS     = 32'd1698362541;
`ifdef MONTRE_SYSID_UPTIME_EN
    localparam bit          UP_EN  = 1'b1;
`else
    localparam bit          UP_EN  = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    montre_sysid_regs #(
        .PRESCALE (P)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: uptime is the count of un-held, un-cleared edges divided by P.
    logic [31:0]     m_scratch;
    bit              m_hold;
    longint unsigned m_cycles;
    logic [31:0]     m_shadow;
    bit              m_pend;
    logic [31:0]     m_data;
    logic [63:0]     m_up_before;
    bit              m_clear;

    function automatic logic [63:0] m_uptime();
        return 64'(m_cycles / P);
    endfunction

    function automatic logic [31:0] model_word(input logic [2:0] a);
        logic [63:0] up;
        up = m_uptime();
        case (a)
            3'd0:    return 32'h0000_0000;
            3'd1:    return TS;
            3'd2:    return UP_EN ? up[31:0] : 32'h0;
            3'd3:    return UP_EN ? m_shadow : 32'h0;
            3'd4:    return m_scratch;
            3'd5:    return UP_EN ? {30'b0, m_hold, 1'b0} : 32'h0;
            3'd6:    return {16'(P), 15'b0, UP_EN};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_scratch = '0;
            m_hold    = 1'b0;
            m_cycles  = 0;
            m_shadow  = '0;
            m_pend    = 1'b0;
            m_data    = '0;
        end else begin
            m_up_before = m_uptime();
            m_pend      = read;
            m_data      = read ? model_word(address) : 32'h0;
            if (UP_EN && read && address == 3'd2) m_shadow = m_up_before[63:32];
            m_clear = UP_EN && write && address == 3'd5 && byteenable[0] && writedata[0];
            if (m_clear)      m_cycles = 0;
            else if (!m_hold) m_cycles = m_cycles + 1;
            if (write && address == 3'd4) begin
                for (int i = 0; i < 4; i++)
                    if (byteenable[i]) m_scratch[8*i +: 8] = writedata[8*i +: 8];
            end
            if (UP_EN && write && address == 3'd5 && byteenable[0]) m_hold = writedata[1];
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("rdv", 32'(readdatavalid), 32'(m_pend && !reset));
            check("rdata", readdata, (m_pend && !reset) ? m_data : 32'h0);
        end
    end

    task automatic bus_cycle(input bit rd, input bit wr, input logic [2:0] a,
                             input logic [31:0] d, input logic [3:0] be);
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = d;
        byteenable = be;
        @(posedge clock);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_cycle(1'b0, 1'b1, a, d, be);
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] data);
        bus_cycle(1'b1, 1'b0, a, 32'h0, 4'h0);
        @(negedge clock);
        data = readdata;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [31:0] v;
    logic [31:0] held;

    initial begin
        reset      = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        byteenable = '0;
        @(posedge clock);
        #1;
        chk_en = 1'b1;
        idle(2);
        @(negedge clock);
        check("rst_rdv", 32'(readdatavalid), 32'h0);
        check("rst_rdata", readdata, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Prescale: 40 cycles after reset with P=4 gives about 10 ticks.
        idle(39);
        do_read(3'd2, v);
        if (UP_EN) check("uptime_40", 32'((v >= 32'd9) && (v <= 32'd11)), 32'h1);
        else       check("uptime_off", v, 32'h0);

        do_read(3'd0, v);  check("sysid", v, 32'h0);
        do_read(3'd1, v);  check("timestamp", v, TS);
        do_read(3'd7, v);  check("reserved", v, 32'h0);
        do_read(3'd6, v);  check("caps", v, {16'(P), 15'b0, UP_EN});

        do_read(3'd4, v);  check("scratch_rst", v, 32'h0);
        do_write(3'd4, 32'hDEAD_BEEF, 4'b1111);
        do_write(3'd4, 32'h0000_1234, 4'b0011);
        do_read(3'd4, v);  check("scratch_be", v, 32'hDEAD_1234);
        do_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        do_read(3'd0, v);  check("id_ro", v, 32'h0);

        // Read and write in the same cycle: the read sees the old value.
        bus_cycle(1'b1, 1'b1, 3'd4, 32'h5555_AAAA, 4'hF);
        @(negedge clock);
        check("rw_old", readdata, 32'hDEAD_1234);
        @(posedge clock);
        #1;
        do_read(3'd4, v);  check("rw_new", v, 32'h5555_AAAA);

        do_write(3'd5, 32'h0000_0002, 4'b0001);
        do_read(3'd5, v);  check("ctrl_hold", v, UP_EN ? 32'h2 : 32'h0);
        do_read(3'd2, held);
        idle(100);
        do_read(3'd2, v);  check("hold_frozen", v, held);

`ifdef MONTRE_SYSID_UPTIME_EN
        force dut.u_uptime.r_uptime = 64'h0000_0001_FFFF_FFFF;
        m_cycles = 64'h0000_0001_FFFF_FFFF * P + (m_cycles % P);
        do_read(3'd2, v);  check("wrap_lo", v, 32'hFFFF_FFFF);
        release dut.u_uptime.r_uptime;
        do_write(3'd5, 32'h0000_0000, 4'b0001);
        idle(3 * P + 2);
        do_read(3'd3, v);  check("snap_hi", v, 32'h0000_0001);
        do_read(3'd2, v);  check("lo_wrapped", 32'(v < 32'd16), 32'h1);

        do_write(3'd5, 32'h0000_0001, 4'b0001);
        do_read(3'd2, v);  check("clear_lo", 32'(v <= 32'd2), 32'h1);
        do_read(3'd5, v);  check("clear_selfclr", 32'(v[0]), 32'h0);
`else
        do_write(3'd5, 32'h0000_0003, 4'b0001);
        do_read(3'd5, v);  check("ctrl_off", v, 32'h0);
        do_read(3'd3, v);  check("hi_off", v, 32'h0);
`endif

        // Reset during an in-flight read: the response must never appear.
        do_write(3'd4, 32'hA5A5_A5A5, 4'hF);
        read    = 1'b1;
        address = 3'd4;
        @(posedge clock);
        #1;
        read  = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("rst_inflight", 32'(readdatavalid), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        do_read(3'd4, v);  check("scratch_after_rst", v, 32'h0);

        for (int i = 0; i < 400; i++) begin
            bus_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
